// File: rtl/alu_operand_loader_pkg.sv
// Shared types and constants for the ALU operand loader front end.
package alu_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_MAX = OP_SHL;

  function automatic logic op_legal(input logic [2:0] o);
    return o <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Bus between the operand loader (master) and the combinational board ALU (slave).
interface alu_operand_loader_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             alu_valid;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;

  modport master (
    output a, b, op, alu_valid,
    input  alu_n, alu_z, alu_c, alu_v
  );

  modport slave (
    input  a, b, op, alu_valid,
    output alu_n, alu_z, alu_c, alu_v
  );
endinterface

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, saturating debounce counter,
// and a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_CYCLES);

  logic          s1, s2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Accept a new level once it has been sampled DEBOUNCE_CYCLES times in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      level <= s2;
      cnt   <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse on the rising edge of the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      level_d     <= level;
      press_pulse <= level & ~level_d;
    end
  end
endmodule

// File: rtl/alu_operand_loader.sv
// Sequencer that loads A, B and the opcode from the switches on debounced
// button presses, presents them to the ALU and latches its flags for the LEDs.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned WIDTH           = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      sw,
  input  logic                  btn_next,
  input  logic                  btn_clr,
  alu_operand_loader_if.master  alu,
  output logic [1:0]            stage,
  output logic [3:0]            flags,
  output logic                  flags_valid,
  output logic                  op_err
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             settle_q;
  logic             next_pulse, clr_pulse;
  logic             load_a, load_b, load_op, set_err, do_clr;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .press_pulse(next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .btn_raw(btn_clr), .press_pulse(clr_pulse)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_d;
  end

  // Next state and datapath load strobes; clr takes priority over next.
  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    set_err = 1'b0;
    do_clr  = 1'b0;
    if (clr_pulse) begin
      state_d = LOAD_A;
      do_clr  = 1'b1;
    end else if (next_pulse) begin
      case (state_q)
        LOAD_A:  begin load_a = 1'b1; state_d = LOAD_B;  end
        LOAD_B:  begin load_b = 1'b1; state_d = LOAD_OP; end
        LOAD_OP: begin
          if (op_legal(sw[2:0])) begin
            load_op = 1'b1;
            state_d = SHOW;
          end else begin
            set_err = 1'b1;
          end
        end
        SHOW:    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  // Operand, opcode and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      op_err <= 1'b0;
    end else begin
      if (do_clr) begin
        a_q    <= '0;
        b_q    <= '0;
        op_q   <= '0;
        op_err <= 1'b0;
      end
      if (load_a) a_q <= sw;
      if (load_b) b_q <= sw;
      if (load_op) begin
        op_q   <= sw[2:0];
        op_err <= 1'b0;
      end
      if (set_err) op_err <= 1'b1;
    end
  end

  // Flag capture: settle_q marks the first full cycle spent in SHOW, so the
  // sample lands on the second edge after entry and is taken only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q    <= 1'b0;
      flags       <= '0;
      flags_valid <= 1'b0;
    end else begin
      settle_q <= (state_q == SHOW) && (state_d == SHOW);
      if (state_d != SHOW) begin
        flags_valid <= 1'b0;
      end else if (settle_q && !flags_valid) begin
        flags       <= {alu.alu_n, alu.alu_z, alu.alu_c, alu.alu_v};
        flags_valid <= 1'b1;
      end
    end
  end

  assign alu.a         = a_q;
  assign alu.b         = b_q;
  assign alu.op        = op_q;
  assign alu.alu_valid = (state_q == SHOW);
  assign stage         = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed plus randomized bench for alu_operand_loader with a transaction-level model.
module tb_alu_operand_loader;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next, btn_clr;
  logic [1:0] stage;
  logic [3:0] flags;
  logic       flags_valid, op_err;
  logic       dn, dz, dc, dv;

  int checks = 0;
  int failures = 0;

  // Model of the architectural state, advanced once per accepted press.
  int         mst;
  logic [3:0] ea, eb, ef;
  logic [2:0] eop;
  logic       eerr, efv;

  alu_operand_loader_if #(.WIDTH(4)) alu_bus ();

  assign alu_bus.alu_n = dn;
  assign alu_bus.alu_z = dz;
  assign alu_bus.alu_c = dc;
  assign alu_bus.alu_v = dv;

  alu_operand_loader #(.DEBOUNCE_CYCLES(D), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .alu(alu_bus.master), .stage(stage), .flags(flags),
    .flags_valid(flags_valid), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0; ea = 0; eb = 0; eop = 0; eerr = 0; efv = 0; ef = 0;
  endtask

  task automatic model_clr();
    mst = 0; ea = 0; eb = 0; eop = 0; eerr = 0; efv = 0;
  endtask

  task automatic model_next(input logic [3:0] s);
    case (mst)
      0: begin ea = s; mst = 1; end
      1: begin eb = s; mst = 2; end
      2: begin
        if (s[2:0] <= 3) begin
          eop = s[2:0]; eerr = 0; mst = 3; efv = 1; ef = {dn, dz, dc, dv};
        end else begin
          eerr = 1;
        end
      end
      default: begin mst = 0; efv = 0; end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"}, 32'(alu_bus.a), 32'(ea));
    chk({tag, ".b"}, 32'(alu_bus.b), 32'(eb));
    chk({tag, ".op"}, 32'(alu_bus.op), 32'(eop));
    chk({tag, ".stage"}, 32'(stage), 32'(mst));
    chk({tag, ".alu_valid"}, 32'(alu_bus.alu_valid), 32'(mst == 3));
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    chk({tag, ".flags_valid"}, 32'(flags_valid), 32'(efv));
    chk({tag, ".op_err"}, 32'(op_err), 32'(eerr));
  endtask

  // Clean press: hold well beyond the debounce window, then release and settle.
  task automatic press(input logic [3:0] s, input logic nxt, input logic clr);
    @(negedge clk);
    sw = s; btn_next = nxt; btn_clr = clr;
    repeat (D + 8) @(negedge clk);
    btn_next = 0; btn_clr = 0;
    repeat (D + 8) @(negedge clk);
    if (clr) model_clr();
    else if (nxt) model_next(s);
  endtask

  initial begin
    int pulses, at, k;
    rst = 1; sw = 0; btn_next = 0; btn_clr = 0;
    dn = 0; dz = 0; dc = 0; dv = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 0;
    repeat (2) @(negedge clk);

    // 1: load 5, 3, op 1 and watch the flag capture timing.
    press(4'd5, 1, 0);
    press(4'd3, 1, 0);
    @(negedge clk);
    sw = 4'd1; btn_next = 1;
    k = 0;
    while (stage != 2'd3 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("t1.show_reached", 32'(stage), 32'd3);
    chk("t1.fv_entry", 32'(flags_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1.fv_edge1", 32'(flags_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1.fv_edge2", 32'(flags_valid), 32'd1);
    model_next(4'd1);
    @(negedge clk); btn_next = 0;
    repeat (D + 8) @(negedge clk);
    check_all("t1");

    // 2: bouncing input then a stable high; exactly one pulse at D+3.
    press(4'd0, 0, 1);
    sw = 4'd4;
    pulses = 0; at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); btn_next = ((c % 4) < 2);
      @(posedge clk); #1;
      if (dut.next_pulse) pulses++;
    end
    @(negedge clk); btn_next = 1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (dut.next_pulse) begin pulses++; at = i; end
    end
    @(negedge clk); btn_next = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dut.next_pulse) pulses++;
    end
    @(negedge clk);
    model_next(4'd4);
    chk("t2.pulse_count", 32'(pulses), 32'd1);
    chk("t2.pulse_latency", 32'(at), 32'(D + 3));
    check_all("t2");

    // 3: illegal opcode keeps LOAD_OP, then a legal one advances.
    press(4'd8, 1, 0);
    press(4'd6, 1, 0);
    check_all("t3.illegal");
    press(4'd2, 1, 0);
    check_all("t3.legal");

    // 4: simultaneous clr and next in SHOW.
    press(4'd5, 1, 1);
    check_all("t4");

    // 5: async reset mid-debounce in LOAD_B.
    press(4'd9, 1, 0);
    check_all("t5.pre");
    @(negedge clk); btn_next = 1;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    model_reset();
    check_all("t5.async");
    @(negedge clk); btn_next = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (dut.next_pulse) pulses++;
    end
    @(negedge clk);
    chk("t5.no_pulse", 32'(pulses), 32'd0);
    check_all("t5.post");
    press(4'd3, 1, 0);
    check_all("t5.first_press");

    // 6: flags latched with C=1, V=1, held while ALU changes, kept after leaving.
    press(4'd0, 0, 1);
    dn = 0; dz = 0; dc = 1; dv = 1;
    press(4'd7, 1, 0);
    press(4'd9, 1, 0);
    press(4'd0, 1, 0);
    chk("t6.flags", 32'(flags), 32'h3);
    dn = 1; dz = 1; dc = 0; dv = 0;
    repeat (6) @(negedge clk);
    check_all("t6.hold");
    press(4'd0, 1, 0);
    chk("t6.flags_kept", 32'(flags), 32'h3);
    check_all("t6.leave");

    // Randomized press sequence against the model.
    for (int n = 0; n < 30; n++) begin
      logic [3:0] s;
      logic [3:0] f;
      logic       cl;
      s  = 4'($urandom_range(0, 15));
      f  = 4'($urandom_range(0, 15));
      cl = ($urandom_range(0, 9) == 0);
      dn = f[3]; dz = f[2]; dc = f[1]; dv = f[0];
      press(s, 1, cl);
      check_all($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front-end sequencer that drives the board ALU from the FPGA switches and push-buttons.
- Captures operand A, then operand B, then the opcode, each from the 4-bit switch bank on a debounced button press.
- Presents the captured values to the ALU as stable registered buses, then latches the returned N/Z/C/V flags for LED display.
- Sits between the board I/O pins and the ALU top level.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable samples required before a button level is accepted (10 ms at 50 MHz)
WIDTH, 4, operand width
OP_MAX, 3, highest legal opcode (0 add, 1 sub, 2 shift right, 3 shift left)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
sw  input  WIDTH  raw switch bank; used for A, for B, and (bits 2:0) for op
btn_next  input  1  raw push-button, active-high, asynchronous to clk
btn_clr  input  1  raw push-button, active-high, asynchronous to clk
alu_n  input  1  ALU negative flag
alu_z  input  1  ALU zero flag
alu_c  input  1  ALU carry flag
alu_v  input  1  ALU overflow flag
a  output  WIDTH  registered operand A to ALU
b  output  WIDTH  registered operand B to ALU
op  output  3  registered opcode to ALU
stage  output  2  current state encoding, for LEDs
alu_valid  output  1  high while a/b/op form a complete operation
flags  output  4  latched {N,Z,C,V}
flags_valid  output  1  flags hold the result of the current operation
op_err  output  1  last opcode entry was illegal

Behaviour:
- Reset (async, active-high): state=LOAD_A; a=0, b=0, op=0, flags=0; alu_valid=0, flags_valid=0, op_err=0; debouncer counters and synchronisers are cleared.
- Button path, per button:
  - 2-FF synchroniser.
  - Counter accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the accepted level produces a one-cycle press pulse.
  - Latency from a stable raw level to the pulse is DEBOUNCE_CYCLES+3 cycles.
  - Holding a button produces exactly one pulse. Releasing produces none.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- States, with stage encoding LOAD_A=0, LOAD_B=1, LOAD_OP=2, SHOW=3:
  - LOAD_A + next_pulse: a<=sw, go to LOAD_B.
  - LOAD_B + next_pulse: b<=sw, go to LOAD_OP.
  - LOAD_OP + next_pulse:
    - sw[2:0]<=OP_MAX: op<=sw[2:0], op_err<=0, go to SHOW.
    - Otherwise: op unchanged, op_err<=1, stay in LOAD_OP.
  - SHOW + next_pulse: go to LOAD_A. a, b and op keep their values until overwritten.
- alu_valid is 1 exactly while state==SHOW, and goes high the cycle after op is captured.
- Flag capture:
  - The ALU is combinational, so flags are sampled on the 2nd clock edge after entering SHOW, giving one full settle cycle.
  - flags_valid rises on that same edge.
  - flags then hold while in SHOW; they are not re-sampled.
  - Leaving SHOW clears flags_valid; flags keep their last value.
- btn_clr pulse:
  - From any state: go to LOAD_A; a, b, op=0; clear alu_valid, flags_valid, op_err.
  - Simultaneous clr and next pulses: clr wins and next is ignored.
- op_err clears on a legal op capture or on clr.
- sw is sampled directly on the pulse cycle; switches are treated as quasi-static and are not synchronised.
- Reset asserted mid-sequence forces the reset values immediately, regardless of state or any pending debounce count.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1) and the counter saturates; it never wraps.

Decomposition:
- Shared package alu_pkg holds:
  - state enum (LOAD_A, LOAD_B, LOAD_OP, SHOW) with its 2-bit encoding;
  - opcode constants OP_ADD=0, OP_SUB=1, OP_SHR=2, OP_SHL=3;
  - OP_MAX.
- One sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, press_pulse), instantiated once for btn_next and once for btn_clr.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, sw=5, clean next press; sw=3, press; sw=1, press -> a=5, b=3, op=1, stage=3, alu_valid=1. With ALU model flags {0,0,0,0}, flags_valid=1 two edges after SHOW entry.
2. Raw btn_next toggles every 2 cycles for 20 cycles, then stays high for 10 cycles -> exactly one press pulse, asserted at DEBOUNCE_CYCLES+3 cycles after the final rise.
3. In LOAD_OP, sw=6, press -> op_err=1, stage stays 2, op unchanged. Then sw=2, press -> op=2, op_err=0, stage=3.
4. In SHOW, btn_clr and btn_next pressed in the same cycle -> stage=0; a=b=op=0; alu_valid=0, flags_valid=0.
5. rst asserted in LOAD_B with a=9 and a debounce count in progress -> a=0 and stage=0 immediately, no pulse after release; first press after reset captures A normally.
6. Full sequence a=7, b=9, op=0 with ALU model C=1, V=1 -> flags=4'b0011 latched. Press next -> stage=0, flags_valid=0, flags still 4'b0011.
